compare_searcher: RTL and testbench

Sequential initiator that finds an unknown WIDTH-bit target held by a magnitude-comparator responder. It uses binary search, issuing guesses over a valid/valid query handshake.
- The responder compares x=target against y=guess and returns one-hot eq/gt/lt.
- This block is the querying end of the Equal/Greater/LessThan comparison path.
- It reports the recovered value, a found flag and the query count.

---
 rtl/compare_pkg.sv | 17 +
 rtl/compare_searcher.sv | 134 +++++++++++++
 tb/tb_compare_searcher.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
// compare_pkg: shared states, one-hot response codes and default width for compare_searcher
package compare_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] RSP_EQ = 3'b100;
    localparam logic [2:0] RSP_GT = 3'b010;
    localparam logic [2:0] RSP_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/compare_searcher.sv
// compare_searcher: binary-search initiator that recovers a comparator's hidden target
//   clk, rst_n (sync, active low)   start: begin a search from IDLE/DONE
//   query_valid/guess: midpoint query, held until cmp_valid
//   cmp_valid, cmp_eq/gt/lt: one-hot responder answer (target vs guess)
//   busy, done, found, result, queries, error, timeout: registered status
//   Optional SEARCH_TIMEOUT_EN: abort to DONE after TIMEOUT_CYCLES unanswered QUERY cycles
module compare_searcher
    import compare_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             query_valid,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       queries,
    output logic             error,
    output logic             timeout
);

    localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};

    state_e           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d, mid;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       queries_q, queries_d, rsp;
    logic             found_q, found_d, error_q, error_d, timeout_q, timeout_d;
    logic             accept, empty, expire;

    assign mid    = lo_q + ((hi_q - lo_q) >> 1);
    assign rsp    = {cmp_eq, cmp_gt, cmp_lt};
    assign accept = state_q == QUERY && cmp_valid;
    // Range collapses when the only remaining candidate is ruled out: gt at hi or lt at lo.
    assign empty  = (rsp == RSP_GT && mid == hi_q) || (rsp == RSP_LT && mid == lo_q);

`ifdef SEARCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_q, wait_d;
    assign wait_d = (state_q == QUERY && !cmp_valid) ? wait_q + 1'b1 : '0;
    assign expire = state_q == QUERY && !cmp_valid && wait_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        result_d  = result_q;
        queries_d = queries_q;
        found_d   = found_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d   = QUERY;
                lo_d      = '0;
                hi_d      = MAX;
                result_d  = '0;
                queries_d = '0;
                found_d   = 1'b0;
                error_d   = 1'b0;
                timeout_d = 1'b0;
            end
            QUERY: if (accept) begin
                queries_d = queries_q + {2'b00, queries_q != 3'd7};
                if (rsp == RSP_EQ) begin
                    result_d = mid[WIDTH-1:0];
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else if (rsp == RSP_GT || rsp == RSP_LT) begin
                    lo_d    = rsp == RSP_GT ? mid + 1'b1 : lo_q;
                    hi_d    = rsp == RSP_LT ? mid - 1'b1 : hi_q;
                    state_d = empty ? DONE : STEP;
                end else begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end else if (expire) begin
                timeout_d = 1'b1;
                state_d   = DONE;
            end
            STEP: state_d = QUERY;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= MAX;
            result_q  <= '0;
            queries_q <= '0;
            found_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            result_q  <= result_d;
            queries_q <= queries_d;
            found_q   <= found_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign query_valid = state_q == QUERY;
    assign guess       = query_valid ? mid[WIDTH-1:0] : '0;
    assign busy        = state_q == QUERY || state_q == STEP;
    assign done        = state_q == DONE;
    assign found       = found_q;
    assign result      = result_q;
    assign queries     = queries_q;
    assign error       = error_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_compare_searcher.sv
// tb_compare_searcher: directed self-checking bench for compare_searcher with an in-bench comparator responder
module tb_compare_searcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       query_valid, cmp_valid, cmp_eq, cmp_gt, cmp_lt;
    logic [3:0] guess, result;
    logic       busy, done, found, error, timeout;
    logic [2:0] queries;

    logic [3:0] target = 4'd0;
    int         mode = 0;
    logic [31:0] glog = '0;
    int         checks = 0;
    int         failures = 0;

    compare_searcher #(.WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .query_valid(query_valid), .guess(guess),
        .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .busy(busy), .done(done), .found(found), .result(result),
        .queries(queries), .error(error), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // mode 0: honest comparator, 1: always lt, 2: eq|gt together, 3: never answers
    always_comb begin
        cmp_valid = query_valid && mode != 3;
        cmp_eq    = mode == 0 ? target == guess : mode == 2;
        cmp_gt    = mode == 0 ? target > guess  : mode == 2;
        cmp_lt    = mode == 0 ? target < guess  : mode == 1;
    end

    always @(negedge clk)
        if (rst_n && query_valid && cmp_valid) glog = {glog[27:0], guess};

    task automatic run_search(input logic [3:0] t, input int m, output bit ok);
        target = t;
        mode   = m;
        glog   = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({query_valid, guess, busy, done, found, result, queries, error, timeout} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0000",
                     {query_valid, guess, busy, done, found, result, queries, error, timeout});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, query_valid} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=000", {busy, done, query_valid});
        end
    endtask

    // ok, guess log, {done,found,result,queries,error,timeout}
    task automatic check_search(input string name, input bit ok, input logic [31:0] exp_log,
                                input logic [10:0] exp_st);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_wait got=no_done want=done", name);
        end
        checks++;
        if (glog !== exp_log) begin
            failures++;
            $display("FAIL %s_guesses got=%h want=%h", name, glog, exp_log);
        end
        checks++;
        if ({done, found, result, queries, error, timeout} !== exp_st) begin
            failures++;
            $display("FAIL %s_status got=%h want=%h", name,
                     {done, found, result, queries, error, timeout}, exp_st);
        end
    endtask

    task automatic test_target9;
        bit ok;
        run_search(4'd9, 0, ok);
        check_search("t9", ok, 32'h7B9, {1'b1, 1'b1, 4'd9, 3'd3, 1'b0, 1'b0});
    endtask

    task automatic test_upper_bound;
        bit ok;
        run_search(4'd15, 0, ok);
        check_search("t15", ok, 32'h7BDEF, {1'b1, 1'b1, 4'd15, 3'd5, 1'b0, 1'b0});
    endtask

    task automatic test_lower_bound;
        bit ok;
        run_search(4'd0, 0, ok);
        check_search("t0", ok, 32'h7310, {1'b1, 1'b1, 4'd0, 3'd4, 1'b0, 1'b0});
    endtask

    task automatic test_lying_responder;
        bit ok;
        run_search(4'd9, 1, ok);
        check_search("lie", ok, 32'h7310, {1'b1, 1'b0, 4'd0, 3'd4, 1'b0, 1'b0});
    endtask

    task automatic test_bad_response;
        bit ok;
        run_search(4'd9, 2, ok);
        check_search("err", ok, 32'h7, {1'b1, 1'b0, 4'd0, 3'd1, 1'b1, 1'b0});
    endtask

    task automatic test_back_to_back;
        target = 4'd12;
        mode   = 0;
        glog   = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if ({done, busy, error, found} !== 4'b0100) begin
            failures++;
            $display("FAIL restart_from_done got=%b want=0100", {done, busy, error, found});
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        checks++;
        if ({glog, done, found, result, queries} !== {32'h7BDC, 1'b1, 1'b1, 4'd12, 3'd4}) begin
            failures++;
            $display("FAIL start_while_busy got=%h/%b%b/%0d/%0d want=00007bdc/11/12/4",
                     glog, done, found, result, queries);
        end
    endtask

    task automatic test_reset_restart;
        bit ok;
        bit hit = 1'b0;
        target = 4'd9;
        mode   = 0;
        glog   = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (query_valid && guess == 4'd9) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL third_query_wait got=none want=guess9");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({query_valid, guess, busy, done, found, result, queries, error, timeout} !== 16'h0) begin
            failures++;
            $display("FAIL midsearch_reset got=%h want=0000",
                     {query_valid, guess, busy, done, found, result, queries, error, timeout});
        end
        rst_n = 1'b1;
        run_search(4'd5, 0, ok);
        check_search("t5", ok, 32'h735, {1'b1, 1'b1, 4'd5, 3'd3, 1'b0, 1'b0});
    endtask

    task automatic test_no_response;
        int qcycles = 0;
        target = 4'd3;
        mode   = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (query_valid) qcycles++;
            @(negedge clk);
        end
`ifdef SEARCH_TIMEOUT_EN
        checks++;
        if ({qcycles, done, timeout, found, error} !== {32'd8, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_abort got=q%0d d%b t%b f%b e%b want=q8 d1 t1 f0 e0",
                     qcycles, done, timeout, found, error);
        end
`else
        checks++;
        if ({done, timeout, busy, query_valid, guess} !== {4'b0011, 4'd7}) begin
            failures++;
            $display("FAIL wait_forever got=d%b t%b b%b qv%b g%0d want=d0 t0 b1 qv1 g7",
                     done, timeout, busy, query_valid, guess);
        end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_target9;
        test_upper_bound;
        test_lower_bound;
        test_lying_responder;
        test_bad_response;
        test_back_to_back;
        test_reset_restart;
        test_no_response;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
